data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Sequences every load/store from the core onto the 8 byte-interleaved data-memory banks (lane i holds bytes with addr[2:0]==i).
//  Sits between core (mem_read/mem_write/funct3/ALU addr/rs2 data) and the 8 bank BRAMs.
//  Generates mem_stall for pcfsm while a load waits out the bank read latency.
//  Returns lane-aligned, sign/zero-extended load data to the writeback mux.
// PARAMETERS
//  ROW_W   12  bank address width; rows per bank = 2**ROW_W (32 KiB total at default)
//  RD_LAT  2   bank read latency in cycles, >=1; a load stalls the core exactly RD_LAT cycles
// PORTS
//  clk        in   1   core clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  mem_read   in   1   load in current instruction
//  mem_write  in   1   store in current instruction
//  funct3     in   3   instr[14:12]: 000 b,001 h,010 w,011 d,100 bu,101 hu,110 wu
//  addr       in   64  byte address from ALU
//  wdata      in   64  store data (rs2), right-justified
//  mem_stall  out  1   hold PC/instruction and block regfile write
//  rdata      out  64  extended load result; valid only in DONE, else 0
//  mem_err    out  1   1-cycle flag: misaligned, illegal funct3 or read&write together
//  bank_en    out  8   per-lane enable
//  bank_we    out  8   per-lane write enable (subset of bank_en)
//  bank_addr  out  ROW_W  row = addr[ROW_W+2:3], shared by all lanes
//  bank_din   out  64  lane i byte = bank_din[8i+7:8i]
//  bank_dout  in   64  lane i read byte at same position
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, counter=0, latched addr/funct3=0; all outputs 0.
//  - Size from funct3[1:0]: 1,2,4,8 bytes; aligned iff addr[2:0] mod size == 0. Row never crossed.
//  - Byte mask m = ((1<<size)-1) << addr[2:0]; bank_din = wdata << 8*addr[2:0].
//  - Legality: store needs funct3<=011; load any except 111; mem_read&mem_write -> illegal.
//    Illegal/misaligned in IDLE: mem_err=1 that cycle, bank_en=0, no stall, rdata=0; stay IDLE.
//  - FSM IDLE / WAIT / DONE:
//    IDLE, legal store: bank_en=bank_we=m same cycle (combinational), mem_stall=0, stay IDLE. Zero-stall store.
//    IDLE, legal load: bank_en=m, mem_stall=1; latch addr[2:0], funct3, row; cnt<=RD_LAT-1;
//      next = WAIT if RD_LAT>1 else DONE.
//    WAIT: bank_en=latched m, bank_addr=latched row, mem_stall=1; cnt--; cnt==1 -> DONE.
//    DONE: mem_stall=0, bank_en=0; rdata = extend(bank_dout >> 8*lat_addr[2:0]) per latched funct3
//      (b/h/w sign-extend, bu/hu/wu zero-extend, d raw); unconditionally -> IDLE.
//  - Load timing at RD_LAT=2: cycle0 IDLE stall=1, cycle1 WAIT stall=1, cycle2 DONE stall=0 + rdata; PC advances at end of cycle2.
//  - Inputs ignored in WAIT/DONE (instruction is held stable by stall); back-to-back loads: next load seen in IDLE the cycle after DONE.
//  - Address bits above ROW_W+2 ignored (wrap modulo bank size).
//  - rst_n asserted mid-load: immediate return to IDLE, stall drops, in-flight read discarded.
// STRUCTURE
//  - Package dmem_pkg: funct3 localparams (F3_B..F3_WU), state encoding (IDLE/WAIT/DONE),
//    function size_of(funct3), NUM_LANES=8.
//  - Sub-module dmem_lane_align (combinational): byte-mask gen, store rotate, load rotate+extend.
//  - Top holds FSM, latency counter, latched addr/funct3, legality/err logic.
// TESTING
//  1 sd addr=0x10 wdata=0x0123456789ABCDEF -> bank_en=bank_we=0xFF, bank_addr=2, stall=0 all cycles.
//  2 sb addr=0x13 wdata=0xAB -> bank_we=0x08, bank_din[31:24]=0xAB; then lb 0x13 -> 2 stall cycles, rdata=0xFFFF_FFFF_FFFF_FFAB; lbu -> 0xAB.
//  3 lw addr=0x14 with lanes 4..7 = 0x80000001 -> rdata=0xFFFFFFFF80000001; lwu -> 0x0000000080000001.
//  4 lh addr=0x11 -> mem_err=1 one cycle, bank_en=0, stall=0, rdata=0, state stays IDLE; same for mem_read&mem_write.
//  5 RD_LAT=3 ld -> stall exactly 3 cycles, DONE on cycle3; back-to-back ld pair -> stall pattern 1,1,1,0,1,1,1,0.
//  6 rst_n low during WAIT -> stall/bank_en drop asynchronously; after release, next ld behaves as test 3 timing.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-interleaved data-memory controller:
// load/store width codes, FSM encoding and access-size helper.
package dmem_pkg;

    localparam int NUM_LANES = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Access size in bytes: 1, 2, 4 or 8; the unsigned variants share funct3[1:0].
    function automatic logic [3:0] size_of(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte-enable mask, store data rotation into
// lane position, and load data rotation plus sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]           off_i,
    input  logic [2:0]           f3_i,
    input  logic [63:0]          wdata_i,
    input  logic [2:0]           ld_off_i,
    input  logic [2:0]           ld_f3_i,
    input  logic [63:0]          dout_i,
    output logic [NUM_LANES-1:0] mask_o,
    output logic [63:0]          din_o,
    output logic [63:0]          rdata_o
);

    logic [7:0]  span;
    logic [15:0] mask_wide;
    logic [63:0] shifted;

    always_comb begin
        span      = 8'hFF >> (4'd8 - size_of(f3_i));
        // Widened so an out-of-row mask never wraps into low lanes.
        mask_wide = {8'h00, span} << off_i;
        mask_o    = mask_wide[7:0];
        din_o     = wdata_i << {off_i, 3'b000};
    end

    always_comb begin
        shifted = dout_i >> {ld_off_i, 3'b000};
        case (ld_f3_i)
            F3_B:    rdata_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    rdata_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:    rdata_o = shifted;
            F3_BU:   rdata_o = {56'd0, shifted[7:0]};
            F3_HU:   rdata_o = {48'd0, shifted[15:0]};
            F3_WU:   rdata_o = {32'd0, shifted[31:0]};
            default: rdata_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: zero-stall stores, fixed-latency loads with core
// stall, legality checking, over 8 byte-interleaved bank BRAMs.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ROW_W  = 12,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [2:0]           funct3,
    input  logic [63:0]          addr,
    input  logic [63:0]          wdata,
    output logic                 mem_stall,
    output logic [63:0]          rdata,
    output logic                 mem_err,
    output logic [NUM_LANES-1:0] bank_en,
    output logic [NUM_LANES-1:0] bank_we,
    output logic [ROW_W-1:0]     bank_addr,
    output logic [63:0]          bank_din,
    input  logic [63:0]          bank_dout
);

    localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        lat_off_q, lat_off_d;
    logic [2:0]        lat_f3_q, lat_f3_d;
    logic [ROW_W-1:0]  lat_row_q, lat_row_d;

    logic [3:0]           size;
    logic                 req, misaligned, illegal, bad, ld_ok, st_ok;
    logic [ROW_W-1:0]     row_in;
    logic [2:0]           off_sel, f3_sel;
    logic [NUM_LANES-1:0] mask;
    logic [63:0]          din_rot, rdata_ext;
    logic                 unused_addr_hi;

    assign unused_addr_hi = ^addr[63:ROW_W+3];

    always_comb begin
        req        = mem_read | mem_write;
        size       = size_of(funct3);
        misaligned = |(addr[2:0] & 3'(size - 4'd1));
        illegal    = (mem_read & mem_write)
                   | (mem_write & funct3[2])
                   | (mem_read & (funct3 == 3'b111));
        bad        = req & (illegal | misaligned);
        ld_ok      = mem_read & ~mem_write & ~bad;
        st_ok      = mem_write & ~mem_read & ~bad;
        row_in     = addr[ROW_W+2:3];
        // The mask is re-driven from the latched access while waiting on the bank.
        off_sel    = (state_q == IDLE) ? addr[2:0] : lat_off_q;
        f3_sel     = (state_q == IDLE) ? funct3    : lat_f3_q;
    end

    dmem_lane_align u_align (
        .off_i    (off_sel),
        .f3_i     (f3_sel),
        .wdata_i  (wdata),
        .ld_off_i (lat_off_q),
        .ld_f3_i  (lat_f3_q),
        .dout_i   (bank_dout),
        .mask_o   (mask),
        .din_o    (din_rot),
        .rdata_o  (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_off_q <= '0;
            lat_f3_q  <= '0;
            lat_row_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_off_q <= lat_off_d;
            lat_f3_q  <= lat_f3_d;
            lat_row_q <= lat_row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_off_d = lat_off_q;
        lat_f3_d  = lat_f3_q;
        lat_row_d = lat_row_q;
        mem_stall = 1'b0;
        mem_err   = 1'b0;
        rdata     = 64'd0;
        bank_en   = '0;
        bank_we   = '0;
        bank_addr = '0;
        bank_din  = 64'd0;

        case (state_q)
            IDLE: begin
                if (bad) begin
                    mem_err = 1'b1;
                end else if (st_ok) begin
                    bank_en   = mask;
                    bank_we   = mask;
                    bank_addr = row_in;
                    bank_din  = din_rot;
                end else if (ld_ok) begin
                    bank_en   = mask;
                    bank_addr = row_in;
                    mem_stall = 1'b1;
                    lat_off_d = addr[2:0];
                    lat_f3_d  = funct3;
                    lat_row_d = row_in;
                    cnt_d     = CNT_INIT;
                    state_d   = (RD_LAT > 1) ? WAIT : DONE;
                end
            end
            WAIT: begin
                bank_en   = mask;
                bank_addr = lat_row_q;
                mem_stall = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rdata   = rdata_ext;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs collapse the moment reset asserts, even with a request still on the inputs.
        if (!rst_n) begin
            mem_stall = 1'b0;
            mem_err   = 1'b0;
            rdata     = 64'd0;
            bank_en   = '0;
            bank_we   = '0;
            bank_addr = '0;
            bank_din  = 64'd0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-addressed reference memory model, emulated
// bank BRAMs with read latency, directed and randomized load/store traffic.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    localparam int ROW_W  = 12;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [63:0] addr, wdata;
    logic        mem_stall, mem_err;
    logic [63:0] rdata;
    logic [7:0]  bank_en, bank_we;
    logic [ROW_W-1:0] bank_addr;
    logic [63:0] bank_din, bank_dout;

    logic        stall3, err3;
    logic [63:0] rdata3, din3, dout3;
    logic [7:0]  en3, we3;
    logic [ROW_W-1:0] baddr3;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ref_mem [0:32767];
    logic [7:0]  bram [0:7][0:4095];
    logic [63:0] rd_pipe [0:RD_LAT-1];

    data_mem_ctrl #(.ROW_W(ROW_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .mem_stall(mem_stall),
        .rdata(rdata), .mem_err(mem_err), .bank_en(bank_en), .bank_we(bank_we),
        .bank_addr(bank_addr), .bank_din(bank_din), .bank_dout(bank_dout)
    );

    data_mem_ctrl #(.ROW_W(ROW_W), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .mem_stall(stall3),
        .rdata(rdata3), .mem_err(err3), .bank_en(en3), .bank_we(we3),
        .bank_addr(baddr3), .bank_din(din3), .bank_dout(dout3)
    );

    // Bank BRAMs: byte write per lane, read data delayed by RD_LAT cycles.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (bank_en[i] && bank_we[i]) bram[i][bank_addr] <= bank_din[8*i +: 8];
            rd_pipe[0][8*i +: 8] <= bram[i][bank_addr];
        end
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bank_dout = rd_pipe[RD_LAT-1];

    function automatic int sz(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [7:0] exp_mask(input logic [2:0] f3, input logic [2:0] off);
        logic [7:0] m = 8'h00;
        for (int k = 0; k < sz(f3); k++) if (int'(off) + k < 8) m[int'(off) + k] = 1'b1;
        return m;
    endfunction

    function automatic logic exp_bad(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [63:0] a);
        if (!(rd || wr)) return 1'b0;
        if (rd && wr) return 1'b1;
        if (wr && f3 >= 3'd4) return 1'b1;
        if (rd && f3 == 3'd7) return 1'b1;
        return (a % 64'(sz(f3))) != 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [2:0] f3);
        logic [63:0] v = 64'd0;
        int n = sz(f3);
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'((a + 64'(k)) % 64'd32768)];
        if (f3[2] == 1'b0 && n < 8 && v[8*n-1])
            for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    endtask

    task automatic idle_cycles(input int n);
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        logic [7:0] m = exp_mask(f3, a[2:0]);
        logic din_ok = 1'b1;
        int off = int'(a[2:0]);
        drive(1'b0, 1'b1, f3, a, wd);
        @(negedge clk);
        checks++;
        if (bank_en !== m || bank_we !== m || mem_stall !== 1'b0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL store_ctrl a=%h f3=%0d en=%h we=%h stall=%b err=%b, want en=we=%h stall=0 err=0",
                     a, f3, bank_en, bank_we, mem_stall, mem_err, m);
        end
        checks++;
        if (bank_addr !== a[14:3]) begin
            errors++;
            $display("FAIL store_row a=%h got %h want %h", a, bank_addr, a[14:3]);
        end
        for (int k = 0; k < sz(f3); k++)
            if (bank_din[8*(off+k) +: 8] !== wd[8*k +: 8]) din_ok = 1'b0;
        checks++;
        if (!din_ok) begin
            errors++;
            $display("FAIL store_din a=%h f3=%0d got %h want wdata %h at lane %0d", a, f3, bank_din, wd, off);
        end
        for (int k = 0; k < sz(f3); k++) ref_mem[int'((a + 64'(k)) % 64'd32768)] = wd[8*k +: 8];
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [63:0] a, output logic [63:0] got);
        logic [63:0] exp = ref_load(a, f3);
        logic [7:0]  m = exp_mask(f3, a[2:0]);
        int stalls = 1;
        drive(1'b1, 1'b0, f3, a, 64'd0);
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b1 || bank_en !== m || bank_we !== 8'h00 ||
            bank_addr !== a[14:3] || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL load_issue a=%h f3=%0d stall=%b en=%h we=%h row=%h err=%b, want 1 %h 00 %h 0",
                     a, f3, mem_stall, bank_en, bank_we, bank_addr, mem_err, m, a[14:3]);
        end
        while (stalls < 10) begin
            @(posedge clk); @(negedge clk);
            if (!mem_stall) break;
            stalls++;
        end
        got = rdata;
        checks++;
        if (stalls != RD_LAT) begin
            errors++;
            $display("FAIL load_stall_len a=%h got %0d cycles want %0d", a, stalls, RD_LAT);
        end
        checks++;
        if (rdata !== exp) begin
            errors++;
            $display("FAIL load_data a=%h f3=%0d got %h want %h", a, f3, rdata, exp);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    endtask

    task automatic do_bad(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] a);
        drive(rd, wr, f3, a, 64'hDEAD_BEEF_0000_00FF);
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b1 || bank_en !== 8'h00 || bank_we !== 8'h00 ||
            mem_stall !== 1'b0 || rdata !== 64'd0) begin
            errors++;
            $display("FAIL illegal_access rd=%b wr=%b f3=%0d a=%h err=%b en=%h we=%h stall=%b rdata=%h, want 1 00 00 0 0",
                     rd, wr, f3, a, mem_err, bank_en, bank_we, mem_stall, rdata);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL illegal_one_cycle err=%b stall=%b, want 0 0", mem_err, mem_stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        dout3 = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_stall, mem_err, bank_en, bank_we} !== 18'd0 || rdata !== 64'd0 ||
            bank_addr !== '0 || bank_din !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs stall=%b err=%b en=%h we=%h row=%h din=%h rdata=%h, want all 0",
                     mem_stall, mem_err, bank_en, bank_we, bank_addr, bank_din, rdata);
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0 || bank_en !== 8'h00 || rdata !== 64'd0) begin
            errors++;
            $display("FAIL post_reset_idle stall=%b en=%h rdata=%h, want 0", mem_stall, bank_en, rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_prefill;
        for (int r = 0; r < 16; r++)
            do_store(F3_D, {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_8000 | 64'(r * 8), {$urandom, $urandom});
    endtask

    task automatic test_sd;
        do_store(F3_D, 64'h10, 64'h0123_4567_89AB_CDEF);
    endtask

    task automatic test_sb_lb;
        logic [63:0] got;
        do_store(F3_B, 64'h13, 64'hAB);
        do_load(F3_B, 64'h13, got);
        checks++;
        if (got !== 64'hFFFF_FFFF_FFFF_FFAB) begin
            errors++;
            $display("FAIL lb_value got %h want ffffffffffffffab", got);
        end
        do_load(F3_BU, 64'h13, got);
        checks++;
        if (got !== 64'hAB) begin
            errors++;
            $display("FAIL lbu_value got %h want ab", got);
        end
    endtask

    task automatic test_lw;
        logic [63:0] got;
        do_store(F3_W, 64'h14, 64'h8000_0001);
        do_load(F3_W, 64'h14, got);
        checks++;
        if (got !== 64'hFFFF_FFFF_8000_0001) begin
            errors++;
            $display("FAIL lw_value got %h want ffffffff80000001", got);
        end
        do_load(F3_WU, 64'h14, got);
        checks++;
        if (got !== 64'h0000_0000_8000_0001) begin
            errors++;
            $display("FAIL lwu_value got %h want 0000000080000001", got);
        end
    endtask

    task automatic test_errors;
        logic [63:0] got;
        do_bad(1'b1, 1'b0, F3_H,   64'h11);
        do_bad(1'b1, 1'b1, F3_D,   64'h10);
        do_bad(1'b0, 1'b1, F3_BU,  64'h10);
        do_bad(1'b1, 1'b0, 3'b111, 64'h10);
        do_bad(1'b0, 1'b1, F3_W,   64'h16);
        do_load(F3_D, 64'h10, got);
    endtask

    task automatic test_random;
        logic [63:0] got;
        for (int i = 0; i < 60; i++) begin
            int kind = $urandom_range(0, 9);
            logic [63:0] a = {$urandom, $urandom};
            logic [2:0] f3;
            logic [2:0] am;
            logic wr = (kind < 4);
            f3 = wr ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
            a[14:0] = 15'($urandom_range(0, 127));
            am = 3'(sz(f3) - 1);
            if (kind != 0 && kind != 9) a[2:0] = a[2:0] & ~am;
            if (exp_bad(~wr, wr, f3, a)) do_bad(~wr, wr, f3, a);
            else if (wr) do_store(f3, a, {$urandom, $urandom});
            else do_load(f3, a, got);
        end
    endtask

    task automatic test_back_to_back;
        int pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
        idle_cycles(5);
        dout3 = {$urandom, $urandom};
        drive(1'b1, 1'b0, F3_D, 64'h8, 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (stall3 !== pat[i][0]) begin
                errors++;
                $display("FAIL b2b_stall cycle=%0d got %b want %0d", i, stall3, pat[i]);
            end
            if (pat[i] == 0) begin
                checks++;
                if (rdata3 !== dout3) begin
                    errors++;
                    $display("FAIL b2b_rdata cycle=%0d got %h want %h", i, rdata3, dout3);
                end
            end
            @(posedge clk); #1;
        end
        idle_cycles(5);
    endtask

    task automatic test_reset_mid_load;
        logic [63:0] got;
        drive(1'b1, 1'b0, F3_D, 64'h10, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_stall !== 1'b0 || bank_en !== 8'h00 || rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_load stall=%b en=%h rdata=%h, want 0 00 0", mem_stall, bank_en, rdata);
        end
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_load(F3_W, 64'h14, got);
        checks++;
        if (got !== 64'hFFFF_FFFF_8000_0001) begin
            errors++;
            $display("FAIL post_reset_lw got %h want ffffffff80000001", got);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ref_mem[i] = 8'h00;
        test_reset;
        test_prefill;
        test_sd;
        test_sb_lb;
        test_lw;
        test_errors;
        test_random;
        test_back_to_back;
        test_reset_mid_load;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1);
    end

endmodule
